axis_upsizer: RTL and testbench
===============================

# axis_upsizer

AXI-Stream width upsizer that packs P_RATIO consecutive narrow beats into one wide beat, lane 0 in the least-significant bits. Sits directly upstream of an axis_pipe register slice instantiated at the wide width, feeding it. It closes early on s_axis_tlast, so short packets are emitted with a per-lane keep mask. It holds a single registered output word and gives full narrow-side throughput when downstream is ready.

## Interface
- P_DATA_WIDTH, 8: narrow (slave-side) beat width in bits.
- P_RATIO, 4: narrow beats per wide beat; integer ≥ 2; a power of two is not required.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- s_axis_tvalid  input  1  narrow beat valid.
- s_axis_tready  output  1  narrow beat accepted when high together with tvalid.
- s_axis_tdata  input  P_DATA_WIDTH  narrow beat data.
- s_axis_tlast  input  1  last narrow beat of packet.
- m_axis_tvalid  output  1  wide beat valid (registered).
- m_axis_tready  input  1  downstream accept.
- m_axis_tdata  output  P_DATA_WIDTH*P_RATIO  wide beat; lane k = bits [k*P_DATA_WIDTH +: P_DATA_WIDTH].
- m_axis_tkeep  output  P_RATIO  per-lane valid mask (one bit per narrow lane, not per byte).
- m_axis_tlast  output  1  wide beat ends a packet.

## Operation
- State: lane counter `lane` (width clog2(P_RATIO), range 0..P_RATIO-1), accumulator holding lanes 0..P_RATIO-2, output register {m_tvalid, m_tdata, m_tkeep, m_tlast}.
- s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational from m_axis_tready, no dependency on s_axis_tvalid/tdata/tlast).
- Accepted beat (s_tvalid && s_tready), non-final (lane < P_RATIO-1 and !tlast): data written to accumulator lane `lane`; lane <= lane+1. Output register untouched.
- Accepted beat, final (lane == P_RATIO-1 or tlast): output register loads accumulator lanes 0..lane-1, incoming data in lane `lane`, lanes above `lane` forced to zero; m_tkeep = bits 0..lane set, others clear; m_tlast = s_tlast; m_tvalid <= 1; lane <= 0.
- Full word without tlast: m_tlast = 0, m_tkeep all ones. A packet that is an exact multiple of P_RATIO ends with m_tkeep all ones and m_tlast = 1.
- Single-beat packet (tlast at lane 0): emitted immediately with tkeep = 1 (only bit 0 set).
- Output handshake: m_tvalid && m_tready with no new final beat: m_tvalid <= 0. With a new final beat in the same cycle: the register reloads and m_tvalid stays 1 (back-to-back words).
- While m_tvalid && !m_tready: s_tready = 0; accumulator and lane hold; m_tdata/tkeep/tlast are stable (AXI rule).
- Accumulator lanes are not cleared after emit; stale contents never reach m_tdata because of the zero-forcing rule.
- Reset (async, any time, including mid-packet): lane = 0, accumulator = 0, m_tvalid = 0, m_tdata = 0, m_tkeep = 0, m_tlast = 0. s_axis_tready therefore reads 1 during and after reset. The partial packet is discarded.

## Timing
- Latency: the wide beat is visible on m_axis the cycle after its final narrow beat is accepted.
- Throughput: 1 narrow beat/cycle sustained while m_tready = 1, including consecutive single-beat tlast packets (1 wide beat/cycle).
- Backpressure: m_tready low stalls s_tready in the same cycle, with no skid. Downstream axis_pipe registers the wide side.
- No combinational path from s_axis_* to m_axis_*. The only combinational path is m_axis_tready -> s_axis_tready.

## Test plan
- W=8, R=4, m_tready=1: send 0x11,0x22,0x33,0x44 (tlast on 0x44) -> one cycle after the last accept: tdata=0x44332211, tkeep=0xF, tlast=1, m_tvalid for exactly 1 cycle.
- Short packet: send 0xAA,0xBB with tlast on 0xBB after a prior full word left stale accumulator data -> tdata=0x0000BBAA, tkeep=0x3, tlast=1; next packet starts at lane 0.
- Back-to-back single-beat packets 0x01..0x08, each with tlast, m_tready=1 -> 8 consecutive wide beats tdata=0x000000NN, tkeep=0x1, no bubbles, s_tready held 1.
- Backpressure: complete a word, hold m_tready=0 for 5 cycles while s_tvalid=1 -> s_tready=0 for all 5 cycles, m_tdata/tkeep/tlast stable, no beats lost. On release, the next accepted beats proceed and the word order is preserved.
- Random s_tvalid/m_tready (50%), 1000 random-length packets -> scoreboard of unpacked lanes matches input; tkeep popcount per packet end = len mod 4 (4 if 0).
- Assert rst_n low after 2 of 4 beats, then release -> all outputs 0 during reset, s_tready=1. The next packet 0x55,0x66,0x77,0x88 emits 0x88776655 with no residue.

Source files
------------

// File: rtl/axis_upsizer_if.sv
// -----------------------------------------------------------------------------
// axis_upsizer_if
// Minimal AXI-Stream bundle used on both sides of axis_upsizer.
//   DATA_W : tdata width in bits
//   KEEP_W : tkeep width (one bit per lane on the wide side; the narrow side
//            carries a single bit that the upsizer ignores)
// Signals : tvalid, tready, tdata, tkeep, tlast
// Modports: master drives tvalid/tdata/tkeep/tlast and samples tready;
//           slave is the mirror image.
// -----------------------------------------------------------------------------
interface axis_upsizer_if #(
   parameter int DATA_W = 8,
   parameter int KEEP_W = 1
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;

   modport master (
      output tvalid,
      output tdata,
      output tkeep,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tkeep,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/axis_upsizer.sv
// -----------------------------------------------------------------------------
// axis_upsizer
// Packs P_RATIO consecutive narrow AXI-Stream beats into one wide beat, lane 0
// in the least-significant bits. A narrow tlast closes the wide beat early and
// the per-lane tkeep marks which lanes carry data. The wide side is a single
// output register; the only combinational path is m_axis.tready ->
// s_axis.tready.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   s_axis : narrow slave stream  (DATA_W = P_DATA_WIDTH, tkeep unused)
//   m_axis : wide master stream   (DATA_W = P_DATA_WIDTH*P_RATIO,
//                                  KEEP_W = P_RATIO, one keep bit per lane)
// -----------------------------------------------------------------------------
module axis_upsizer #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_RATIO      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   axis_upsizer_if.slave    s_axis,
   axis_upsizer_if.master   m_axis
);

   localparam int                LANE_W    = $clog2(P_RATIO);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(P_RATIO - 1);

   // Lane counter and accumulator for lanes 0..P_RATIO-2; the top lane is
   // never stored because the beat that fills it goes straight to the output.
   logic [LANE_W-1:0]                       lane;
   logic [P_RATIO-2:0][P_DATA_WIDTH-1:0]    acc;

   // Output register
   logic                                    m_tvalid_q;
   logic [P_RATIO*P_DATA_WIDTH-1:0]         m_tdata_q;
   logic [P_RATIO-1:0]                      m_tkeep_q;
   logic                                    m_tlast_q;

   logic                                    s_ready;
   logic                                    accept;
   logic                                    is_final;
   logic [P_RATIO-1:0][P_DATA_WIDTH-1:0]    acc_ext;
   logic [P_RATIO-1:0][P_DATA_WIDTH-1:0]    word_next;
   logic [P_RATIO-1:0]                      keep_next;

   // Narrow-side keep carries no information for this block.
   logic                                    unused_s_tkeep;
   assign unused_s_tkeep = ^s_axis.tkeep;

   // The output register can take a new word when it is empty or being
   // drained this cycle; the accumulator stalls with it, so no skid buffer.
   assign s_ready  = !m_tvalid_q || m_axis.tready;
   assign accept   = s_axis.tvalid && s_ready;
   assign is_final = (lane == LAST_LANE) || s_axis.tlast;

   // Pad the accumulator to full width so every lane can be indexed uniformly.
   assign acc_ext = {{P_DATA_WIDTH{1'b0}}, acc};

   // Assemble the outgoing word: stored lanes below `lane`, the incoming beat
   // at `lane`, zeros above. Zero-forcing is what keeps stale accumulator
   // contents from a previous word out of a short word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      word_next = '0;
      keep_next = '0;
      for (int k = 0; k < P_RATIO; k++) begin
         if (LANE_W'(k) < lane) begin
            word_next[k] = acc_ext[k];
         end else if (LANE_W'(k) == lane) begin
            word_next[k] = s_axis.tdata;
         end
         keep_next[k] = (LANE_W'(k) <= lane);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the accumulator is an array but it is reset like any other
         // register so a packet cut by reset leaves no residue.
         lane       <= '0;
         acc        <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tlast_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register sees
         // the pre-edge values of the others regardless of statement order.
         if (accept && !is_final) begin
            for (int k = 0; k < P_RATIO - 1; k++) begin
               if (lane == LANE_W'(k)) begin
                  acc[k] <= s_axis.tdata;
               end
            end
            lane <= lane + 1'b1;
         end

         if (accept && is_final) begin
            // Reload covers the back-to-back case where the previous word
            // is handed off on this same edge.
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= word_next;
            m_tkeep_q  <= keep_next;
            m_tlast_q  <= s_axis.tlast;
            lane       <= '0;
         end else if (m_axis.tready) begin
            m_tvalid_q <= 1'b0;
         end
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = m_tvalid_q;
   assign m_axis.tdata  = m_tdata_q;
   assign m_axis.tkeep  = m_tkeep_q;
   assign m_axis.tlast  = m_tlast_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// -----------------------------------------------------------------------------
// tb_axis_upsizer
// Self-checking bench for axis_upsizer (P_DATA_WIDTH = 8, P_RATIO = 4).
// Stimulus pushes the expected wide beats into a queue before the narrow
// beats are sent; an independent monitor pops and compares on every wide
// handshake.
// -----------------------------------------------------------------------------
module tb_axis_upsizer;

   localparam int W = 8;
   localparam int R = 4;

   typedef struct {
      logic [W*R-1:0] data;
      logic [R-1:0]   keep;
      logic           last;
   } exp_t;

   logic clk;
   logic rst_n;

   axis_upsizer_if #(.DATA_W(W),     .KEEP_W(1)) s_if ();
   axis_upsizer_if #(.DATA_W(W * R), .KEEP_W(R)) m_if ();

   axis_upsizer #(
      .P_DATA_WIDTH (W),
      .P_RATIO      (R)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_axis (s_if.slave),
      .m_axis (m_if.master)
   );

   assign s_if.tkeep = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   rand_ready = 1'b0;
   exp_t exp_q[$];
   int   end_q[$];
   int   last_accept_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [W*R-1:0] d, input logic [R-1:0] k, input logic l);
      exp_t e;
      e.data = d;
      e.keep = k;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Reference packing of a whole packet into wide words, byte by byte.
   task automatic push_packet(input logic [W-1:0] b[$]);
      int n;
      n = b.size();
      for (int idx = 0; idx < n; idx += R) begin
         exp_t e;
         e.data = '0;
         e.keep = '0;
         for (int k = 0; k < R; k++) begin
            if (idx + k < n) begin
               e.data[k*W +: W] = b[idx + k];
               e.keep[k]        = 1'b1;
            end
         end
         e.last = (idx + R >= n);
         exp_q.push_back(e);
      end
      end_q.push_back(((n % R) == 0) ? R : (n % R));
   endtask

   // Entered and left at posedge+#1. Holds the beat until accepted.
   task automatic send_beat(input logic [W-1:0] d, input logic last, input bit rnd);
      int waited;
      if (rnd) begin
         while ($urandom_range(1, 0) == 0) begin
            s_if.tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = last;
      waited      = 0;
      @(negedge clk);
      while (s_if.tready !== 1'b1 && waited < 1000) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 1000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: s_tready low for %0d cycles, expected acceptance", waited);
      end
      last_accept_cyc = cyc;
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
   endtask

   // Monitor: compares every wide handshake against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", m_if.tdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("beat_tdata", 64'(m_if.tdata), 64'(e.data));
            check("beat_tkeep", 64'(m_if.tkeep), 64'(e.keep));
            check("beat_tlast", 64'(m_if.tlast), 64'(e.last));
            if (m_if.tlast === 1'b1) begin
               if (end_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL end_keep: got packet end, expected none pending");
               end else begin
                  check("end_keep_count", 64'($countones(m_if.tkeep)), 64'(end_q.pop_front()));
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) m_if.tready = 1'($urandom_range(1, 0));
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
      check({tag, "_m_tdata"},  64'(m_if.tdata),  64'd0);
      check({tag, "_m_tkeep"},  64'(m_if.tkeep),  64'd0);
      check({tag, "_m_tlast"},  64'(m_if.tlast),  64'd0);
      check({tag, "_s_tready"}, 64'(s_if.tready), 64'd1);
   endtask

   initial begin
      logic [W-1:0] pkt[$];
      int           acc_cyc[8];
      int           len;
      int           drain;

      rst_n       = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b0;
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_if.tready = 1'b1;

      // Full packet of exactly one word, single-cycle valid.
      push_exp(32'h4433_2211, 4'hF, 1'b1);
      end_q.push_back(4);
      send_beat(8'h11, 1'b0, 1'b0);
      send_beat(8'h22, 1'b0, 1'b0);
      send_beat(8'h33, 1'b0, 1'b0);
      send_beat(8'h44, 1'b1, 1'b0);
      check("full_latency_valid", 64'(m_if.tvalid), 64'd1);
      @(posedge clk);
      #1;
      check("full_one_cycle", 64'(m_if.tvalid), 64'd0);

      // Short packet on top of stale accumulator contents.
      push_exp(32'h0000_BBAA, 4'h3, 1'b1);
      end_q.push_back(2);
      send_beat(8'hAA, 1'b0, 1'b0);
      send_beat(8'hBB, 1'b1, 1'b0);

      // Back-to-back single-beat packets: one accept per cycle.
      for (int i = 1; i <= 8; i++) begin
         push_exp(32'(i), 4'h1, 1'b1);
         end_q.push_back(1);
      end
      for (int i = 1; i <= 8; i++) begin
         send_beat(8'(i), 1'b1, 1'b0);
         acc_cyc[i-1] = last_accept_cyc;
      end
      check("single_beat_no_bubbles", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);

      // Backpressure: 5-beat packet, word held for 5 cycles while a beat waits.
      push_exp(32'hD4D3_D2D1, 4'hF, 1'b0);
      push_exp(32'h0000_00E1, 4'h1, 1'b1);
      end_q.push_back(1);
      send_beat(8'hD1, 1'b0, 1'b0);
      send_beat(8'hD2, 1'b0, 1'b0);
      send_beat(8'hD3, 1'b0, 1'b0);
      send_beat(8'hD4, 1'b0, 1'b0);
      m_if.tready = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'hE1;
      s_if.tlast  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_s_tready_low", 64'(s_if.tready), 64'd0);
         check("bp_tdata_stable", 64'(m_if.tdata), 64'hD4D3_D2D1);
         check("bp_tkeep_stable", 64'(m_if.tkeep), 64'hF);
         check("bp_tlast_stable", 64'(m_if.tlast), 64'd0);
         @(posedge clk);
         #1;
      end
      m_if.tready = 1'b1;
      send_beat(8'hE1, 1'b1, 1'b0);

      // Random traffic, 50% valid and 50% ready.
      rand_ready = 1'b1;
      for (int p = 0; p < 1000; p++) begin
         len = $urandom_range(9, 1);
         pkt.delete();
         for (int b = 0; b < len; b++) pkt.push_back(8'($urandom));
         push_packet(pkt);
         for (int b = 0; b < len; b++) send_beat(pkt[b], (b == len - 1), 1'b1);
      end
      @(posedge clk);
      rand_ready  = 1'b0;
      #2;
      m_if.tready = 1'b1;
      drain = 0;
      while (exp_q.size() != 0 && drain < 200) begin
         @(posedge clk);
         drain++;
      end
      #1;
      check("random_queue_drained", 64'(exp_q.size()), 64'd0);

      // Reset mid-packet discards the partial word.
      send_beat(8'h10, 1'b0, 1'b0);
      send_beat(8'h20, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      check_reset_outputs("mid_rst_hold");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_exp(32'h8877_6655, 4'hF, 1'b1);
      end_q.push_back(4);
      send_beat(8'h55, 1'b0, 1'b0);
      send_beat(8'h66, 1'b0, 1'b0);
      send_beat(8'h77, 1'b0, 1'b0);
      send_beat(8'h88, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check("final_end_queue_empty", 64'(end_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
